// File: rtl/rot_share_arbiter_if.sv
// Request/response bundle for the shared rotate arbiter.
// master = requesting side, slave = arbiter.
interface rot_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [3*NREQ-1:0] req_amt;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              busy;

  modport master (
    output req_valid, req_data, req_amt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_amt, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/rot_share_arbiter.sv
// Round-robin shared 8-bit right-rotate unit, one op in flight.
// ROT_STATS_EN adds op_cnt, a saturating count of completed responses.
module rot_share_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  rot_share_arbiter_if.slave bus
`ifdef ROT_STATS_EN
  ,
  output logic [15:0] op_cnt
`endif
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t          state, state_d;
  logic [ID_W-1:0] ptr, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      data_q, data_d;

  logic [ID_W-1:0] win, win_hi, win_lo;
  logic            any, any_hi, any_lo;
  logic [7:0]      win_data;
  logic [2:0]      win_amt;
  logic [15:0]     dd;
  logic [7:0]      rot_res;

  // Two priority scans: at/above ptr first, then below ptr (wrap).
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    any_hi = 1'b0;
    any_lo = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (ID_W'(i) >= ptr) begin
          win_hi = ID_W'(i);
          any_hi = 1'b1;
        end else begin
          win_lo = ID_W'(i);
          any_lo = 1'b1;
        end
      end
    end
    any = any_hi | any_lo;
    win = any_hi ? win_hi : win_lo;
  end

  // Only the granted lane reaches the rotator, so other lanes' X stays out.
  always_comb begin
    win_data = 8'h00;
    win_amt  = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == win) begin
        win_data = bus.req_data[8*i +: 8];
        win_amt  = bus.req_amt[3*i +: 3];
      end
    end
  end

  always_comb begin
    dd      = {win_data, win_data} >> win_amt;
    rot_res = dd[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      data_q <= 8'h00;
      id_q   <= '0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      data_q <= data_d;
      id_q   <= id_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    data_d  = data_q;
    id_d    = id_q;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_d = RESP;
          ptr_d   = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
          data_d  = rot_res;
          id_d    = win;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state == IDLE && any) bus.req_ready[win] = 1'b1;
    bus.rsp_valid = (state == RESP);
    bus.busy      = (state == RESP);
    bus.rsp_data  = data_q;
    bus.rsp_id    = id_q;
  end

`ifdef ROT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_cnt <= 16'h0000;
    end else if (state == RESP && bus.rsp_ready && op_cnt != 16'hFFFF) begin
      op_cnt <= op_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_rot_share_arbiter.sv
// Scoreboard bench for rot_share_arbiter: directed cases plus random traffic
// against a round-robin reference model.
module tb_rot_share_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef struct {
    logic [7:0]      d;
    logic [ID_W-1:0] id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rot_share_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

`ifdef ROT_STATS_EN
  logic [15:0] op_cnt;
`endif

  rot_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
`ifdef ROT_STATS_EN
    ,
    .op_cnt(op_cnt)
`endif
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_busy = 0;
  int   m_ptr = 0;
  int   m_ops = 0;
  bit   chk_rst = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rot_ref(input logic [7:0] d, input int amt);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = d[(k + amt) % 8];
    return r;
  endfunction

  // One cycle: drive at negedge, check/advance the model 1ns later.
  task automatic step(input logic [NREQ-1:0] v, input logic [8*NREQ-1:0] d,
                      input logic [3*NREQ-1:0] a, input logic rr,
                      input logic rn);
    int w;
    int i;
    logic [NREQ-1:0] er;
    exp_t e;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_amt   = a;
    bus.rsp_ready = rr;
    rst_n         = rn;
    #1;
    if (chk_rst) begin
      chk("rst_data", 32'(bus.rsp_data), 32'h0);
      chk("rst_id", 32'(bus.rsp_id), 32'h0);
      chk_rst = 0;
    end
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy));
`ifdef ROT_STATS_EN
    chk("op_cnt", 32'(op_cnt), (m_ops > 65535) ? 32'hFFFF : 32'(m_ops));
`endif
    if (!rn) begin
      chk("ready_in_rst", 32'(bus.req_ready), 32'h0);
      m_busy = 0;
      m_ptr  = 0;
      m_ops  = 0;
      sb.delete();
      chk_rst = 1;
    end else if (!m_busy) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (w < 0 && v[i]) w = i;
      end
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      if (w >= 0) begin
        e.d  = rot_ref(d[8*w +: 8], int'(a[3*w +: 3]));
        e.id = ID_W'(w);
        sb.push_back(e);
        m_ptr  = (w + 1) % NREQ;
        m_busy = 1;
      end
    end else begin
      chk("ready_busy", 32'(bus.req_ready), 32'h0);
      if (rr) begin
        m_busy = 0;
        m_ops++;
      end
    end
  endtask

  // Monitor: every presented response must match the queue head.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got id %0d want none", bus.rsp_id);
      end else begin
        chk("rsp_data", 32'(bus.rsp_data), 32'(sb[0].d));
        chk("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
        if (bus.rsp_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_amt   = '0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    step(4'b0000, 32'h0, 12'h0, 1'b0, 1'b0);
    step(4'b0000, 32'h0, 12'h0, 1'b0, 1'b0);
    // B4 ror 3 = 96 on req 0
    step(4'b0001, 32'h000000B4, 12'h003, 1'b1, 1'b1);
    step(4'b0000, 32'h0, 12'h0, 1'b1, 1'b1);
    // 01 ror 7 = 02 on req 1
    step(4'b0010, 32'h00000100, 12'h038, 1'b1, 1'b1);
    step(4'b0000, 32'h0, 12'h0, 1'b1, 1'b1);
    // A5 ror 0 on req 3
    step(4'b1000, 32'hA5000000, 12'h000, 1'b1, 1'b1);
    step(4'b0000, 32'h0, 12'h0, 1'b1, 1'b1);
    for (int n = 0; n < 12; n++)
      step(4'b1111, 32'h11223344, 12'h5A3, 1'b1, 1'b1);
    step(4'b1111, 32'hDEADBEEF, 12'h9C6, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++)
      step(4'b1111, 32'h01234567, 12'h111, 1'b0, 1'b1);
    step(4'b1111, 32'h01234567, 12'h111, 1'b1, 1'b1);
    step(4'b0000, 32'h0, 12'h0, 1'b1, 1'b1);
    // reset while a result is pending
    step(4'b0010, 32'h0000C300, 12'h010, 1'b0, 1'b1);
    step(4'b1111, 32'h0, 12'h0, 1'b0, 1'b0);
    step(4'b0100, 32'h00F00000, 12'h100, 1'b1, 1'b1);
    step(4'b0000, 32'h0, 12'h0, 1'b0, 1'b1);
    step(4'b0000, 32'h0, 12'h0, 1'b0, 1'b0);
    step(4'b1111, 32'h8040_2010, 12'hFAC, 1'b1, 1'b1);
    step(4'b0000, 32'h0, 12'h0, 1'b1, 1'b1);
    for (int n = 0; n < 600; n++)
      step(NREQ'($urandom), $urandom, 12'($urandom), ($urandom % 4) != 0,
           ($urandom % 64) != 0);
    for (int n = 0; n < 4; n++)
      step(4'b0000, 32'h0, 12'h0, 1'b1, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rot_share_arbiter.md
Name: rot_share_arbiter

Overview:
- Shares one 8-bit right-rotate unit among NREQ requesters using round-robin arbitration.
- Each requester presents a data byte and a 3-bit rotate amount over a valid/ready handshake.
- The block rotates the granted operand, registers the result, and returns it with the requester ID on a valid/ready response channel.
- It sits between the requesting engines and the team's shared rotate datapath; one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (legal range 2..8).
- ID_W, 2, width of rsp_id; must equal $clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_data  input  8*NREQ  operand; requester i uses bits [8i+7:8i].
- req_amt  input  3*NREQ  rotate amount; requester i uses bits [3i+2:3i].
- req_ready  output  NREQ  one-hot grant/accept strobe.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  8  rotated byte.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- busy  output  1  high in RESP state.

Behaviour:
- Rotate function: rsp_data[k] = d[(k+amt) mod 8], i.e. rotate right by amt. amt=0 passes the operand through unchanged. No other arithmetic is performed.
- FSM states: IDLE and RESP.
- IDLE:
  - req_ready = onehot(winner) when any req_valid is high; otherwise all zero. req_ready is combinational from req_valid and ptr.
  - winner = first i with req_valid[i]=1, scanning ptr, ptr+1, … with wrap modulo NREQ.
  - On handshake (req_valid[i] & req_ready[i]): register rsp_data = rot(data_i, amt_i) and rsp_id = i; set ptr = (i+1) mod NREQ; go to RESP.
- RESP:
  - rsp_valid=1, busy=1, req_ready all zero.
  - rsp_data and rsp_id are held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE.
- Latency and throughput: the result is valid on the cycle after request acceptance. Maximum throughput is one operation per 2 cycles. A new request is never accepted in the same cycle as the response handshake.
- req_valid may drop without acceptance; the block does not record the request.
- req_valid changing while a request is not granted: arbitration is re-evaluated every IDLE cycle.
- Pointer wrap: ptr=NREQ-1 followed by a grant to NREQ-1 sets ptr=0.
- Reset (synchronous, rst_n=0 sampled at a clock edge), including mid-operation:
  - state=IDLE, ptr=0, rsp_valid=0, busy=0, rsp_data=8'h00, rsp_id=0.
  - Any pending result is discarded.
  - req_ready is forced to zero while rst_n=0.
- X on req_data or req_amt of non-granted requesters must not propagate into the outputs.

Optional Feature:
- Macro: ROT_STATS_EN.
- Defined:
  - Adds output op_cnt[15:0], a count of completed response handshakes.
  - Saturates at 16'hFFFF and resets to 0.
  - Increments on the cycle after rsp_valid & rsp_ready.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic rotate: req_valid=4'b0001, data0=8'hB4, amt0=3 → req_ready=4'b0001 that cycle; next cycle rsp_valid=1, rsp_data=8'h96, rsp_id=0.
- Amount boundaries:
  - data=8'h01, amt=7 → rsp_data=8'h02.
  - data=8'hA5, amt=0 → rsp_data=8'hA5.
- Fairness: all four req_valid held high with rsp_ready=1 → grant order 0,1,2,3,0,1; one grant every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_data and rsp_id stable, req_ready=0, busy=1. Raising rsp_ready → IDLE on the next cycle.
- Reset mid-operation: rst_n=0 for one edge during RESP → rsp_valid=0 and ptr=0 after that edge. The next request from requester 2 alone is granted; with all requesters valid, 0 is granted first.
- ROT_STATS_EN: 3 completed operations → op_cnt=3. Preload near 16'hFFFF (force) and run 2 more operations → op_cnt holds at 16'hFFFF.
